// File: rtl/sort_engine.sv
// Bubble-sort engine for the 256x16 distributed memory: owns the memory port while busy,
// sorts in place ascending or descending, pulses FIN when done and counts busy cycles.
module sort_engine #(
  parameter int DEPTH = 256,
  parameter int DW    = 16
) (
  input  logic          CLK100MHZ,
  input  logic          rstn,
  input  logic          run,
  input  logic          desc,
  output logic [7:0]    mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  input  logic [DW-1:0] mem_spo,
  output logic          busy,
  output logic          FIN,
  output logic [31:0]   cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP,
    S_WR,
    S_TAIL,
    S_DONE
  } state_e;

  localparam logic [7:0] LAST_INIT = 8'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] cur_q, cur_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [7:0]    i_q, i_d;
  logic [7:0]    last_q, last_d;
  logic          swapped_q, swapped_d;
  logic          ord_q, ord_d;
  logic [31:0]   cycles_q, cycles_d;
  logic          out_of_order;

  // Strict compare: equal neighbours never swap, which keeps the sort stable.
  always_comb begin
    out_of_order = ord_q ? (cur_q < mem_spo) : (cur_q > mem_spo);
  end

  always_ff @(posedge CLK100MHZ or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      lo_q      <= '0;
      i_q       <= '0;
      last_q    <= '0;
      swapped_q <= 1'b0;
      ord_q     <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      lo_q      <= lo_d;
      i_q       <= i_d;
      last_q    <= last_d;
      swapped_q <= swapped_d;
      ord_q     <= ord_d;
      cycles_q  <= cycles_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    lo_d      = lo_q;
    i_d       = i_q;
    last_d    = last_q;
    swapped_d = swapped_q;
    ord_d     = ord_q;
    cycles_d  = (state_q != S_IDLE) ? cycles_q + 32'd1 : cycles_q;
    mem_a     = '0;
    mem_d     = '0;
    mem_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          ord_d     = desc;
          last_d    = LAST_INIT;
          swapped_d = 1'b0;
          cycles_d  = '0;
          if (DEPTH == 1) state_d = S_DONE;
          else            state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        mem_a   = '0;
        cur_d   = mem_spo;
        i_d     = 8'd1;
        state_d = S_CMP;
      end
      S_CMP: begin
        mem_a = i_q;
        if (out_of_order) begin
          lo_d      = mem_spo;
          swapped_d = 1'b1;
        end else begin
          lo_d  = cur_q;
          cur_d = mem_spo;
        end
        state_d = S_WR;
      end
      S_WR: begin
        mem_a  = i_q - 8'd1;
        mem_d  = lo_q;
        mem_we = 1'b1;
        if (i_q == last_q) begin
          state_d = S_TAIL;
        end else begin
          i_d     = i_q + 8'd1;
          state_d = S_CMP;
        end
      end
      S_TAIL: begin
        mem_a  = last_q;
        mem_d  = cur_q;
        mem_we = 1'b1;
        if (!swapped_q || last_q == 8'd1) begin
          state_d = S_DONE;
        end else begin
          last_d    = last_q - 8'd1;
          swapped_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign FIN    = (state_q == S_DONE);
  assign cycles = cycles_q;

endmodule
